// File: rtl/issue_queue_param_pkg.sv
// rtl/issue_queue_param_pkg.sv - shared optypes, FU indices and entry layout for the issue queue
package issue_queue_param_pkg;
    localparam int PC_W       = 32;
    localparam int DEF_TAG_W  = 6;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_OP_W   = 4;

    typedef enum logic [DEF_OP_W-1:0] {
        OP_INV = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR = 4'd4,
        OP_XOR = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7, OP_SLT = 4'd8, OP_LW = 4'd9, OP_SW = 4'd10
    } optype_e;

    localparam int FU_ALU0 = 0;
    localparam int FU_ALU1 = 1;
    localparam int FU_MEM  = 2;

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic [DEF_OP_W-1:0]   op;
        logic [DEF_DATA_W-1:0] imm;
        logic [DEF_TAG_W-1:0]  dest;
        logic [DEF_TAG_W-1:0]  rob;
        logic                  s1_rdy;
        logic [DEF_TAG_W-1:0]  s1_tag;
        logic [DEF_DATA_W-1:0] s1_data;
        logic                  s2_rdy;
        logic [DEF_TAG_W-1:0]  s2_tag;
        logic [DEF_DATA_W-1:0] s2_data;
    } iq_entry_t;

    // Round-robin over the ALU ports only; the memory port is bound directly.
    function automatic int rr_next(input int ptr, input int num_alu);
        return (ptr >= num_alu - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/issue_queue_param_if.sv
// rtl/issue_queue_param_if.sv - dispatch, writeback and issue bundle of the issue queue
interface issue_queue_param_if #(
    parameter int DEPTH  = 16,
    parameter int NUM_FU = 3,
    parameter int NUM_WB = 3,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    localparam int PC_W = issue_queue_param_pkg::PC_W;

    logic                     disp_valid;
    logic                     disp_ready;
    logic                     flush;
    logic [PC_W-1:0]          disp_pc;
    logic [OP_W-1:0]          disp_op;
    logic                     disp_is_mem;
    logic [TAG_W-1:0]         disp_dest;
    logic [TAG_W-1:0]         disp_rob;
    logic [DATA_W-1:0]        disp_imm;
    logic [TAG_W-1:0]         disp_src1_tag;
    logic                     disp_src1_rdy;
    logic [DATA_W-1:0]        disp_src1_data;
    logic [TAG_W-1:0]         disp_src2_tag;
    logic                     disp_src2_rdy;
    logic [DATA_W-1:0]        disp_src2_data;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*TAG_W-1:0]  wb_tag;
    logic [NUM_WB*DATA_W-1:0] wb_data;
    logic [NUM_FU-1:0]        fu_ready;
    logic [NUM_FU-1:0]        iss_valid;
    logic [NUM_FU*PC_W-1:0]   iss_pc;
    logic [NUM_FU*OP_W-1:0]   iss_op;
    logic [NUM_FU*DATA_W-1:0] iss_src1;
    logic [NUM_FU*DATA_W-1:0] iss_src2;
    logic [NUM_FU*DATA_W-1:0] iss_imm;
    logic [NUM_FU*TAG_W-1:0]  iss_dest;
    logic [NUM_FU*TAG_W-1:0]  iss_rob;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output disp_valid, flush, disp_pc, disp_op, disp_is_mem, disp_dest, disp_rob, disp_imm,
               disp_src1_tag, disp_src1_rdy, disp_src1_data, disp_src2_tag, disp_src2_rdy,
               disp_src2_data, wb_valid, wb_tag, wb_data, fu_ready,
        input  disp_ready, iss_valid, iss_pc, iss_op, iss_src1, iss_src2, iss_imm, iss_dest,
               iss_rob, count
    );
    modport slave (
        input  disp_valid, flush, disp_pc, disp_op, disp_is_mem, disp_dest, disp_rob, disp_imm,
               disp_src1_tag, disp_src1_rdy, disp_src1_data, disp_src2_tag, disp_src2_rdy,
               disp_src2_data, wb_valid, wb_tag, wb_data, fu_ready,
        output disp_ready, iss_valid, iss_pc, iss_op, iss_src1, iss_src2, iss_imm, iss_dest,
               iss_rob, count
    );
endinterface

// File: rtl/iq_age_select.sv
// rtl/iq_age_select.sv - combinational oldest-requester picker driven by the age matrix
module iq_age_select #(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]         req,
    input  logic [DEPTH*DEPTH-1:0]   age,
    output logic [DEPTH-1:0]         grant,
    output logic                     found,
    output logic [$clog2(DEPTH)-1:0] idx
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] blocked;

    // age[j*DEPTH+i] set means entry j is older than entry i
    always_comb begin
        blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                blocked[i] = blocked[i] | (req[j] & age[j*DEPTH+i]);
            end
        end
        grant = req & ~blocked;
        found = |grant;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/issue_queue_param.sv
// rtl/issue_queue_param.sv - age-ordered issue queue with wakeup, bypass and per-FU select
module issue_queue_param
    import issue_queue_param_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int NUM_FU = 3,
    parameter int NUM_WB = 3,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W
) (
    input logic clk,
    input logic rst,
    issue_queue_param_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [TAG_W-1:0]  dest;
        logic [TAG_W-1:0]  rob;
        logic [FU_W-1:0]   fu;
        logic              s1_rdy;
        logic [TAG_W-1:0]  s1_tag;
        logic [DATA_W-1:0] s1_data;
        logic              s2_rdy;
        logic [TAG_W-1:0]  s2_tag;
        logic [DATA_W-1:0] s2_data;
    } entry_t;

    entry_t            ent_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  age_q [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [FU_W-1:0]   rr_q;
    logic [NUM_FU-1:0] iss_valid_q;
    logic [PC_W-1:0]   iss_pc_q   [NUM_FU];
    logic [OP_W-1:0]   iss_op_q   [NUM_FU];
    logic [DATA_W-1:0] iss_src1_q [NUM_FU];
    logic [DATA_W-1:0] iss_src2_q [NUM_FU];
    logic [DATA_W-1:0] iss_imm_q  [NUM_FU];
    logic [TAG_W-1:0]  iss_dest_q [NUM_FU];
    logic [TAG_W-1:0]  iss_rob_q  [NUM_FU];

    // Returns {hit, data}; scanning downward lets the lowest matching bus win.
    function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] tag,
                                              input logic [NUM_WB-1:0] v,
                                              input logic [NUM_WB*TAG_W-1:0] t,
                                              input logic [NUM_WB*DATA_W-1:0] d);
        logic [DATA_W:0] hit;
        hit = '0;
        for (int b = NUM_WB - 1; b >= 0; b--) begin
            if (v[b] && t[b*TAG_W +: TAG_W] == tag) hit = {1'b1, d[b*DATA_W +: DATA_W]};
        end
        return hit;
    endfunction

    function automatic logic [DATA_W:0] src_value(input logic [TAG_W-1:0] tag, input logic rdy,
                                                  input logic [DATA_W-1:0] data,
                                                  input logic [DATA_W:0] bypass);
        if (tag == '0) return {1'b1, {DATA_W{1'b0}}};
        if (rdy) return {1'b1, data};
        return bypass;
    endfunction

    logic [DATA_W:0]      wake1 [DEPTH];
    logic [DATA_W:0]      wake2 [DEPTH];
    logic [IDX_W-1:0]     alloc_idx;
    logic [DEPTH-1:0]     alloc_mask;
    entry_t               new_ent;
    logic                 disp_ready;
    logic                 disp_acc;
    logic [DEPTH-1:0]     req [NUM_FU];
    logic [DEPTH-1:0]     grant [NUM_FU];
    logic                 found [NUM_FU];
    logic [IDX_W-1:0]     sel_idx [NUM_FU];
    logic [DEPTH*DEPTH-1:0] age_flat;
    logic [NUM_FU-1:0]    issue;
    logic [DEPTH-1:0]     issued_mask;
    logic [CNT_W-1:0]     num_iss;

    assign disp_ready = !rst && (count_q < CNT_W'(DEPTH));
    assign disp_acc   = bus.disp_valid && disp_ready && (bus.disp_op != '0) && !bus.flush;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = snoop(ent_q[i].s1_tag, bus.wb_valid, bus.wb_tag, bus.wb_data);
            wake2[i] = snoop(ent_q[i].s2_tag, bus.wb_valid, bus.wb_tag, bus.wb_data);
        end
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = IDX_W'(i);
        end
        alloc_mask            = '0;
        alloc_mask[alloc_idx] = disp_acc;
        new_ent        = '0;
        new_ent.pc     = bus.disp_pc;
        new_ent.op     = bus.disp_op;
        new_ent.imm    = bus.disp_imm;
        new_ent.dest   = bus.disp_dest;
        new_ent.rob    = bus.disp_rob;
        new_ent.fu     = bus.disp_is_mem ? FU_W'(NUM_FU - 1) : rr_q;
        new_ent.s1_tag = bus.disp_src1_tag;
        new_ent.s2_tag = bus.disp_src2_tag;
        {new_ent.s1_rdy, new_ent.s1_data} = src_value(bus.disp_src1_tag, bus.disp_src1_rdy,
            bus.disp_src1_data, snoop(bus.disp_src1_tag, bus.wb_valid, bus.wb_tag, bus.wb_data));
        {new_ent.s2_rdy, new_ent.s2_data} = src_value(bus.disp_src2_tag, bus.disp_src2_rdy,
            bus.disp_src2_data, snoop(bus.disp_src2_tag, bus.wb_valid, bus.wb_tag, bus.wb_data));
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) age_flat[i*DEPTH +: DEPTH] = age_q[i];
        for (int f = 0; f < NUM_FU; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                req[f][i] = valid_q[i] && (ent_q[i].fu == FU_W'(f)) && ent_q[i].s1_rdy && ent_q[i].s2_rdy;
            end
        end
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
        iq_age_select #(.DEPTH(DEPTH)) u_sel (
            .req   (req[f]),
            .age   (age_flat),
            .grant (grant[f]),
            .found (found[f]),
            .idx   (sel_idx[f])
        );
    end

    always_comb begin
        issue       = '0;
        issued_mask = '0;
        num_iss     = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (found[f] && bus.fu_ready[f]) begin
                issue[f]    = 1'b1;
                issued_mask = issued_mask | grant[f];
                num_iss     = num_iss + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            count_q     <= '0;
            rr_q        <= '0;
            iss_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
                age_q[i] <= '0;
            end
            for (int f = 0; f < NUM_FU; f++) begin
                iss_pc_q[f]   <= '0;
                iss_op_q[f]   <= '0;
                iss_src1_q[f] <= '0;
                iss_src2_q[f] <= '0;
                iss_imm_q[f]  <= '0;
                iss_dest_q[f] <= '0;
                iss_rob_q[f]  <= '0;
            end
        end else if (bus.flush) begin
            valid_q     <= '0;
            count_q     <= '0;
            iss_valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && !ent_q[i].s1_rdy && wake1[i][DATA_W]) begin
                    ent_q[i].s1_rdy  <= 1'b1;
                    ent_q[i].s1_data <= wake1[i][DATA_W-1:0];
                end
                if (valid_q[i] && !ent_q[i].s2_rdy && wake2[i][DATA_W]) begin
                    ent_q[i].s2_rdy  <= 1'b1;
                    ent_q[i].s2_data <= wake2[i][DATA_W-1:0];
                end
            end
            if (disp_acc) begin
                ent_q[alloc_idx] <= new_ent;
                age_q[alloc_idx] <= '0;
                // every entry live before this edge is older than the newcomer
                for (int j = 0; j < DEPTH; j++) age_q[j][alloc_idx] <= valid_q[j];
                if (!bus.disp_is_mem) rr_q <= FU_W'(rr_next(int'(rr_q), NUM_FU - 1));
            end
            valid_q     <= (valid_q & ~issued_mask) | alloc_mask;
            count_q     <= count_q + CNT_W'(disp_acc) - num_iss;
            iss_valid_q <= issue;
            for (int f = 0; f < NUM_FU; f++) begin
                if (issue[f]) begin
                    iss_pc_q[f]   <= ent_q[sel_idx[f]].pc;
                    iss_op_q[f]   <= ent_q[sel_idx[f]].op;
                    iss_src1_q[f] <= ent_q[sel_idx[f]].s1_data;
                    iss_src2_q[f] <= ent_q[sel_idx[f]].s2_data;
                    iss_imm_q[f]  <= ent_q[sel_idx[f]].imm;
                    iss_dest_q[f] <= ent_q[sel_idx[f]].dest;
                    iss_rob_q[f]  <= ent_q[sel_idx[f]].rob;
                end
            end
        end
    end

    assign bus.disp_ready = disp_ready;
    assign bus.count      = count_q;
    assign bus.iss_valid  = iss_valid_q;
    for (genvar f = 0; f < NUM_FU; f++) begin : g_out
        assign bus.iss_pc[f*PC_W +: PC_W]       = iss_pc_q[f];
        assign bus.iss_op[f*OP_W +: OP_W]       = iss_op_q[f];
        assign bus.iss_src1[f*DATA_W +: DATA_W] = iss_src1_q[f];
        assign bus.iss_src2[f*DATA_W +: DATA_W] = iss_src2_q[f];
        assign bus.iss_imm[f*DATA_W +: DATA_W]  = iss_imm_q[f];
        assign bus.iss_dest[f*TAG_W +: TAG_W]   = iss_dest_q[f];
        assign bus.iss_rob[f*TAG_W +: TAG_W]    = iss_rob_q[f];
    end
endmodule
